// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp_pkg
// Purpose  : Shared definitions for the multi-port register file: soft-clear
//            FSM state encoding and the hardwired-zero register address.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_mp_pkg;

  // Soft-clear engine states
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Entry that reads as zero when ZERO_REG is enabled
  localparam int RF_ZERO_ADDR = 0;

endpackage : reg_file_mp_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module   : rf_read_port
// Purpose  : One combinational read port of reg_file_mp: array mux, optional
//            same-cycle write bypass with byte merge, hardwired-zero check.
// Ports    : i_addr       read address
//            i_mem        full storage array
//            i_bypass_ok  1 when the write ports may be forwarded (FSM idle)
//            i_wr_en      write enables, ports 0/1
//            i_wr_addr    write addresses, port j at [j*ADDR_W +: ADDR_W]
//            i_wr_data    write data, port j at [j*DATA_W +: DATA_W]
//            i_wr_be      byte enables, port j at [j*DATA_W/8 +: DATA_W/8]
//            o_data       read data
// Revision : 1.0 - initial release
// ============================================================================
module rf_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_mem [2**ADDR_W],
  input  logic                  i_bypass_ok,
  input  logic [1:0]            i_wr_en,
  input  logic [2*ADDR_W-1:0]   i_wr_addr,
  input  logic [2*DATA_W-1:0]   i_wr_data,
  input  logic [2*DATA_W/8-1:0] i_wr_be,
  output logic [DATA_W-1:0]     o_data
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] w_word;

  always_comb begin
    w_word = i_mem[i_addr];
    // Port 1 is merged after port 0 so its bytes take precedence.
    if (BYPASS != 0 && i_bypass_ok) begin
      for (int j = 0; j < 2; j++) begin
        if (i_wr_en[j] && i_wr_addr[j*ADDR_W +: ADDR_W] == i_addr) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (i_wr_be[j*NBYTES + b]) begin
              w_word[8*b +: 8] = i_wr_data[j*DATA_W + 8*b +: 8];
            end
          end
        end
      end
    end
    // Applied last so a bypassed write to entry 0 can never leak through.
    if (ZERO_REG != 0 && i_addr == ADDR_W'(RF_ZERO_ADDR)) begin
      w_word = '0;
    end
    o_data = w_word;
  end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Parametrised multi-port register file for the MIPS datapath.
//            NRD combinational read ports, two byte-enabled write ports,
//            optional write-to-read bypass, optional hardwired-zero entry 0,
//            and a soft-clear engine that zeroes one entry per cycle.
// Ports    : clock     rising-edge clock
//            reset_n   asynchronous active-low reset
//            rd_addr   read addresses, port i at [i*ADDR_W +: ADDR_W]
//            rd_data   read data, port i at [i*DATA_W +: DATA_W]
//            wr_en     write enables, ports 0/1
//            wr_addr   write addresses, port j at [j*ADDR_W +: ADDR_W]
//            wr_data   write data, port j at [j*DATA_W +: DATA_W]
//            wr_be     byte enables, port j at [j*DATA_W/8 +: DATA_W/8]
//            clr_req   single-cycle soft-clear request
//            clr_busy  soft clear in progress (writes dropped)
//            clr_done  one-cycle pulse on soft-clear completion
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic [1:0]            wr_en,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic [2*DATA_W/8-1:0] wr_be,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_clr_done;
  logic              w_clr_done_nxt;

  logic [ADDR_W-1:0] w_waddr0;
  logic [ADDR_W-1:0] w_waddr1;

  assign w_waddr0 = wr_addr[0      +: ADDR_W];
  assign w_waddr1 = wr_addr[ADDR_W +: ADDR_W];

  // --------------------------------------------------------------------------
  // Soft-clear FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RF_IDLE;
      r_ptr      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_clr_done_nxt = 1'b0;
    case (r_state)
      RF_IDLE: begin
        if (clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      RF_CLEAR: begin
        // Pointer wraps to 0 naturally when the last entry is cleared.
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == '1) begin
          w_state_nxt    = RF_IDLE;
          w_clr_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = RF_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign clr_busy = (r_state == RF_CLEAR);
  assign clr_done = r_clr_done;

  // --------------------------------------------------------------------------
  // Storage array: write ports while idle, one entry zeroed per cycle in clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_mem[e] <= '0;
      end
    end else if (r_state == RF_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (!(ZERO_REG != 0 && e == RF_ZERO_ADDR)) begin
          for (int b = 0; b < NBYTES; b++) begin
            // Port 1 has priority on overlapping bytes of the same entry.
            if (wr_en[1] && w_waddr1 == ADDR_W'(e) && wr_be[NBYTES + b]) begin
              r_mem[e][8*b +: 8] <= wr_data[DATA_W + 8*b +: 8];
            end else if (wr_en[0] && w_waddr0 == ADDR_W'(e) && wr_be[b]) begin
              r_mem[e][8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NRD; i++) begin : g_rd_port
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .i_addr      (rd_addr[i*ADDR_W +: ADDR_W]),
      .i_mem       (r_mem),
      .i_bypass_ok (r_state == RF_IDLE),
      .i_wr_en     (wr_en),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_wr_be     (wr_be),
      .o_data      (rd_data[i*DATA_W +: DATA_W])
    );
  end : g_rd_port

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Self-checking bench for reg_file_mp. Two instances share all
//            inputs: A (BYPASS=1, ZERO_REG=1) and B (BYPASS=0, ZERO_REG=0).
//            A behavioural model of both register files is checked every cycle,
//            alongside directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clock;
  logic           reset_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_a;
  logic [NR*DW-1:0] rd_data_b;
  logic [1:0]     wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [7:0]     wr_be;
  logic           clr_req;
  logic           clr_busy_a, clr_busy_b;
  logic           clr_done_a, clr_done_b;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // Behavioural model: two plain arrays plus busy flag and clear pointer
  // --------------------------------------------------------------------------
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_ptr  = 0;

  initial begin
    for (int a = 0; a < 32; a++) begin
      mem_a[a] = '0;
      mem_b[a] = '0;
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < 32; a++) begin
        mem_a[a] <= '0;
        mem_b[a] <= '0;
      end
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_ptr  <= 0;
    end else if (m_busy) begin
      mem_a[m_ptr] <= '0;
      mem_b[m_ptr] <= '0;
      if (m_ptr == 31) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_ptr  <= 0;
      end else begin
        m_done <= 1'b0;
        m_ptr  <= m_ptr + 1;
      end
    end else begin
      m_done <= 1'b0;
      // Port 1 applied after port 0: the later update wins per byte.
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j]) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_be[j*4 + b]) begin
              if (wr_addr[j*AW +: AW] != 5'd0)
                mem_a[wr_addr[j*AW +: AW]][8*b +: 8] <= wr_data[j*DW + 8*b +: 8];
              mem_b[wr_addr[j*AW +: AW]][8*b +: 8] <= wr_data[j*DW + 8*b +: 8];
            end
          end
        end
      end
      if (clr_req) begin
        m_busy <= 1'b1;
        m_ptr  <= 0;
      end
    end
  end

  // Expected read value for instance 0 (A) or 1 (B)
  function automatic logic [31:0] rd_exp(int inst, logic [4:0] a);
    logic [31:0] w;
    w = (inst == 0) ? mem_a[a] : mem_b[a];
    if (inst == 0 && !m_busy) begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_be[j*4 + b]) w[8*b +: 8] = wr_data[j*DW + 8*b +: 8];
          end
        end
      end
    end
    if (inst == 0 && a == 5'd0) w = '0;
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [4:0] a;
    for (int i = 0; i < NR; i++) begin
      a = rd_addr[i*AW +: AW];
      lit($sformatf("A.rd%0d[r%0d]", i, a), rd_data_a[i*DW +: DW], rd_exp(0, a));
      lit($sformatf("B.rd%0d[r%0d]", i, a), rd_data_b[i*DW +: DW], rd_exp(1, a));
    end
    lit("A.busy", {31'b0, clr_busy_a}, {31'b0, m_busy});
    lit("B.busy", {31'b0, clr_busy_b}, {31'b0, m_busy});
    lit("A.done", {31'b0, clr_done_a}, {31'b0, m_done});
    lit("B.done", {31'b0, clr_done_b}, {31'b0, m_done});
  endtask

  // Inputs are driven at negedge+1; outputs compared at negedge+3.
  task automatic step();
    check_all();
    @(negedge clock);
    #1;
  endtask

  task automatic cyc();
    #2;
    step();
  endtask

  task automatic fill(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'(i)};
      wr_data = {32'h0, 32'hA5000000 | 32'(i)};
      wr_be   = 8'h0F;
      rd_addr = {5'(i), 5'(i)};
      cyc();
    end
    wr_en = 2'b00;
  endtask

  task automatic all_zero(input string nm);
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      #2;
      lit({nm, ".A"}, rd_data_a[31:0], 32'h0);
      lit({nm, ".B"}, rd_data_b[63:32], 32'h0);
      step();
    end
  endtask

  int bc, dc;

  initial begin
    reset_n = 1'b0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    clr_req = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    reset_n = 1'b1;
    #2;
    lit("rst.busy", {31'b0, clr_busy_a}, 32'h0);
    lit("rst.done", {31'b0, clr_done_a}, 32'h0);
    lit("rst.rd", rd_data_b[31:0], 32'h0);
    step();

    // Write / read, same-cycle bypass on A only
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'hDEADBEEF};
    wr_be   = 8'h0F;
    rd_addr = {5'd5, 5'd5};
    #2;
    lit("byp.A0", rd_data_a[31:0],  32'hDEADBEEF);
    lit("byp.A1", rd_data_a[63:32], 32'hDEADBEEF);
    lit("nobyp.B0", rd_data_b[31:0], 32'h0);
    step();
    wr_en = 2'b00;
    #2;
    lit("wr.A1", rd_data_a[63:32], 32'hDEADBEEF);
    lit("wr.B0", rd_data_b[31:0],  32'hDEADBEEF);
    step();

    // Dual-write collision on r7
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h22222222, 32'h11111111};
    wr_be   = 8'h3F;
    rd_addr = {5'd7, 5'd7};
    #2;
    lit("coll.byp.A", rd_data_a[31:0], 32'h11112222);
    step();
    wr_en = 2'b00;
    #2;
    lit("coll.A", rd_data_a[31:0],  32'h11112222);
    lit("coll.B", rd_data_b[63:32], 32'h11112222);
    step();

    // Zero register
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'h0, 32'hFFFFFFFF};
    wr_be   = 8'h0F;
    rd_addr = {5'd0, 5'd0};
    cyc();
    wr_en = 2'b00;
    #2;
    lit("zero.A", rd_data_a[31:0], 32'h0);
    lit("zero.B", rd_data_b[31:0], 32'hFFFFFFFF);
    step();

    // Asynchronous reset mid-cycle with live data
    rd_addr = {5'd7, 5'd5};
    #2;
    reset_n = 1'b0;
    #1;
    lit("arst.A0", rd_data_a[31:0],  32'h0);
    lit("arst.A1", rd_data_a[63:32], 32'h0);
    lit("arst.B0", rd_data_b[31:0],  32'h0);
    lit("arst.B1", rd_data_b[63:32], 32'h0);
    lit("arst.busy", {31'b0, clr_busy_a}, 32'h0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    cyc();

    // Randomized traffic, including occasional soft clears
    for (int n = 0; n < 400; n++) begin
      wr_en   = 2'($urandom_range(0, 3));
      wr_addr = 10'($urandom);
      wr_data = {$urandom, $urandom};
      wr_be   = 8'($urandom);
      rd_addr = 10'($urandom);
      clr_req = ($urandom_range(0, 40) == 0);
      cyc();
    end
    wr_en   = 2'b00;
    clr_req = 1'b0;
    repeat (40) cyc();

    // Soft clear of a full array
    fill(0, 31);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd9};
    wr_data = {32'h0, 32'h99999999};
    wr_be   = 8'h0F;
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    bc = 0;
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd2};
        wr_data = {32'h0, 32'h12345678};
        rd_addr = {5'd2, 5'd2};
      end else begin
        wr_en   = 2'b00;
        rd_addr = 10'($urandom);
      end
      #2;
      if (k == 10) lit("clr.nobyp.A", rd_data_a[31:0], 32'h0);
      bc += int'(clr_busy_a);
      dc += int'(clr_done_a);
      step();
    end
    wr_en = 2'b00;
    lit("clr.busy_cycles", 32'(bc), 32'd32);
    lit("clr.done_pulses", 32'(dc), 32'd1);
    all_zero("clr.empty");

    // Reset in the middle of a soft clear, then restart
    fill(20, 25);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (10) cyc();
    rd_addr = {5'd25, 5'd24};
    #2;
    lit("mid.busy", {31'b0, clr_busy_a}, 32'h1);
    reset_n = 1'b0;
    #1;
    lit("mid.arst.busy", {31'b0, clr_busy_a}, 32'h0);
    lit("mid.arst.A", rd_data_a[31:0],  32'h0);
    lit("mid.arst.B", rd_data_b[63:32], 32'h0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      #2;
      dc += int'(clr_done_a) + int'(clr_done_b);
      step();
    end
    lit("mid.no_done", 32'(dc), 32'd0);
    all_zero("mid.empty");

    fill(1, 3);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      rd_addr = {5'd3, 5'd1};
      #2;
      bc += int'(clr_busy_b);
      step();
    end
    lit("restart.busy_cycles", 32'(bc), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_file_mp
`default_nettype wire
